pong_score_ctrl: RTL and testbench

//  Match/score controller for BASPONG, sitting between anim_gen and SevenSegment.

---
 rtl/pong_score_ctrl_if.sv | 24 ++
 rtl/pong_score_ctrl.sv | 155 +++++++++++++++
 tb/tb_pong_score_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_score_ctrl_if.sv
// Score/match bus between the BASPONG glue (start button, anim_gen flags) and the
// score controller.
interface pong_score_ctrl_if #(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned SCORE_W     = 4
);
   logic                           start;
   logic [NUM_PLAYERS-1:0]         score_evt;
   logic                           ball_enable;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores;
   logic [NUM_PLAYERS-1:0]         winner;
   logic                           game_over;
   logic [1:0]                     state;

   modport master (
      output start, score_evt,
      input  ball_enable, scores, winner, game_over, state
   );

   modport slave (
      input  start, score_evt,
      output ball_enable, scores, winner, game_over, state
   );
endinterface

// File: rtl/pong_score_ctrl.sv
// BASPONG match/score controller: serve delay, per-player scoring, win detection.
// Optional build macro WIN_BY_TWO_EN requires a two-point lead to win.
module pong_score_ctrl #(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned SCORE_W     = 4,
   parameter int unsigned WIN_SCORE   = 9,
   parameter int unsigned SERVE_DLY   = 50_000_000
) (
   input logic              clk_50,
   input logic              reset,
   pong_score_ctrl_if.slave bus
);

   localparam int unsigned      CntW     = (SERVE_DLY > 1) ? $clog2(SERVE_DLY) : 1;
   localparam int unsigned      IdxW     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam logic [SCORE_W-1:0] ScoreMax = '1;
   localparam logic [SCORE_W-1:0] WinVal   = SCORE_W'(WIN_SCORE);
   localparam logic [CntW-1:0]  CntLoad  = CntW'(SERVE_DLY - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StServe = 2'd1,
      StPlay  = 2'd2,
      StOver  = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [SCORE_W-1:0]     scores_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]     scores_d [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] winner_q, winner_d;
   logic                   start_q;
   logic [NUM_PLAYERS-1:0] evt_q;

   logic                   start_rise;
   logic [NUM_PLAYERS-1:0] evt_rise;
   logic                   hit;
   logic [IdxW-1:0]        hit_idx;
   logic [SCORE_W-1:0]     cur_score;
   logic [SCORE_W-1:0]     new_score;
   logic                   is_win;

   assign start_rise = bus.start & ~start_q;
   assign evt_rise   = bus.score_evt & ~evt_q;

   // Descending scan so the lowest simultaneous rise wins the credit.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
         if (evt_rise[i]) begin
            hit     = 1'b1;
            hit_idx = IdxW'(i);
         end
      end
   end

   assign cur_score = scores_q[hit_idx];
   assign new_score = (cur_score == ScoreMax) ? ScoreMax : cur_score + SCORE_W'(1);

`ifdef WIN_BY_TWO_EN
   logic lead_ok;

   always_comb begin
      lead_ok = 1'b1;
      for (int j = 0; j < int'(NUM_PLAYERS); j++) begin
         if ((IdxW'(j) != hit_idx) &&
             ({1'b0, new_score} < ({1'b0, scores_q[j]} + (SCORE_W+1)'(2)))) begin
            lead_ok = 1'b0;
         end
      end
      is_win = ((new_score >= WinVal) && lead_ok) || (new_score == ScoreMax);
   end
`else
   assign is_win = (new_score == WinVal) || (new_score == ScoreMax);
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      scores_d = scores_q;
      winner_d = winner_q;
      unique case (state_q)
         StIdle: begin
            if (start_rise) begin
               state_d = StServe;
               cnt_d   = CntLoad;
            end
         end
         StServe: begin
            if (cnt_q == '0) begin
               state_d = StPlay;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StPlay: begin
            if (hit) begin
               scores_d[hit_idx] = new_score;
               if (is_win) begin
                  state_d           = StOver;
                  winner_d          = '0;
                  winner_d[hit_idx] = 1'b1;
               end else begin
                  state_d = StServe;
                  cnt_d   = CntLoad;
               end
            end
         end
         StOver: begin
            if (start_rise) begin
               for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                  scores_d[i] = '0;
               end
               winner_d = '0;
               state_d  = StServe;
               cnt_d    = CntLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         winner_q <= '0;
         start_q  <= 1'b0;
         evt_q    <= '0;
         for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            scores_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         winner_q <= winner_d;
         start_q  <= bus.start;
         evt_q    <= bus.score_evt;
         for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            scores_q[i] <= scores_d[i];
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_PLAYERS); g++) begin : g_pack
      assign bus.scores[g*SCORE_W +: SCORE_W] = scores_q[g];
   end

   assign bus.ball_enable = (state_q == StPlay);
   assign bus.game_over   = (state_q == StOver);
   assign bus.winner      = winner_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Self-checking bench for pong_score_ctrl: directed match scenarios plus random
// button/score traffic checked against a cycle-level behavioural model.
module tb_pong_score_ctrl;

   localparam int unsigned NP  = 2;
   localparam int unsigned SW  = 4;
   localparam int unsigned WIN = 3;
   localparam int unsigned DLY = 4;
   localparam int          MAXS = (1 << SW) - 1;

   logic clk_50 = 1'b0;
   logic reset  = 1'b1;
   int   total  = 0;
   int   bad    = 0;

   pong_score_ctrl_if #(.NUM_PLAYERS(NP), .SCORE_W(SW)) bus ();

   pong_score_ctrl #(
      .NUM_PLAYERS(NP),
      .SCORE_W    (SW),
      .WIN_SCORE  (WIN),
      .SERVE_DLY  (DLY)
   ) dut (
      .clk_50(clk_50),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk_50 = ~clk_50;

   // Model: 0 idle, 1 serve, 2 play, 3 over; m_left = serve cycles still to spend.
   int          m_state;
   int          m_sc [NP];
   int          m_win;
   int          m_left;
   bit          m_ps;
   bit [NP-1:0] m_pe;

   function automatic void model_reset();
      m_state = 0;
      m_win   = 0;
      m_left  = 0;
      m_ps    = 1'b0;
      m_pe    = '0;
      for (int i = 0; i < int'(NP); i++) m_sc[i] = 0;
   endfunction

   function automatic bit wins(int who, int val);
      bit ok;
      if (val == MAXS) return 1'b1;
`ifdef WIN_BY_TWO_EN
      ok = (val >= int'(WIN));
      for (int j = 0; j < int'(NP); j++)
         if (j != who && val - m_sc[j] < 2) ok = 1'b0;
`else
      ok = (val == int'(WIN));
`endif
      return ok;
   endfunction

   function automatic void model_edge(bit s, bit [NP-1:0] e);
      bit          srise;
      bit [NP-1:0] erise;
      int          who;
      int          val;
      srise = s && !m_ps;
      erise = e & ~m_pe;
      m_ps  = s;
      m_pe  = e;
      case (m_state)
         0: if (srise) begin m_state = 1; m_left = DLY; end
         1: begin
            m_left--;
            if (m_left == 0) m_state = 2;
         end
         2: if (erise != 0) begin
            who = 0;
            while (!erise[who]) who++;
            val = (m_sc[who] + 1 > MAXS) ? MAXS : m_sc[who] + 1;
            if (wins(who, val)) begin
               m_state = 3;
               m_win   = 1 << who;
            end else begin
               m_state = 1;
               m_left  = DLY;
            end
            m_sc[who] = val;
         end
         default: if (srise) begin
            for (int i = 0; i < int'(NP); i++) m_sc[i] = 0;
            m_win   = 0;
            m_state = 1;
            m_left  = DLY;
         end
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string ctx);
      logic [NP*SW-1:0] es;
      es = '0;
      for (int i = 0; i < int'(NP); i++) es[i*SW +: SW] = SW'(m_sc[i]);
      check({ctx, ".state"}, 32'(bus.state), 32'(m_state));
      check({ctx, ".scores"}, 32'(bus.scores), 32'(es));
      check({ctx, ".winner"}, 32'(bus.winner), 32'(m_win));
      check({ctx, ".ball_en"}, 32'(bus.ball_enable), 32'(m_state == 2));
      check({ctx, ".game_over"}, 32'(bus.game_over), 32'(m_state == 3));
   endtask

   task automatic cyc(string ctx, bit s, bit [NP-1:0] e);
      bus.start     = s;
      bus.score_evt = e;
      @(posedge clk_50);
      model_edge(s, e);
      #1;
      check_all(ctx);
   endtask

   task automatic do_reset();
      bus.start     = 1'b0;
      bus.score_evt = '0;
      reset         = 1'b1;
      model_reset();
      #3;
      check_all("rst");
      @(negedge clk_50);
      reset = 1'b0;
   endtask

   // One point for the given mask in PLAY, then idle through the following serve.
   task automatic point(string ctx, bit [NP-1:0] e);
      cyc(ctx, 1'b0, e);
      for (int k = 0; k < int'(DLY); k++) cyc(ctx, 1'b0, '0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.score_evt = '0;
      model_reset();
      do_reset();
      check("rst.state_const", 32'(bus.state), 32'd0);

      // Serve lasts exactly DLY cycles.
      cyc("t1", 1'b1, '0);
      check("t1.serve", 32'(bus.state), 32'd1);
      for (int k = 1; k < int'(DLY); k++) cyc("t1", 1'b0, '0);
      check("t1.still_serve", 32'(bus.state), 32'd1);
      cyc("t1", 1'b0, '0);
      check("t1.play", 32'(bus.state), 32'd2);
      check("t1.ball_en", 32'(bus.ball_enable), 32'd1);

      // Held score flag counts once.
      for (int k = 0; k < 10; k++) cyc("t2", 1'b0, 2'b01);
      check("t2.scores", 32'(bus.scores), 32'h01);
      check("t2.play_again", 32'(bus.state), 32'd2);
      cyc("t2", 1'b0, '0);

      // Simultaneous rises credit player 0 only.
      cyc("t3", 1'b0, 2'b11);
      check("t3.scores", 32'(bus.scores), 32'h02);
      for (int k = 0; k < int'(DLY); k++) cyc("t3", 1'b0, '0);

      // Player 1 runs to a win; later flags ignored; start restarts.
      for (int k = 0; k < 8 && m_state != 3; k++) point("t4", 2'b10);
      check("t4.over", 32'(bus.state), 32'd3);
      check("t4.winner", 32'(bus.winner), 32'b10);
      check("t4.game_over", 32'(bus.game_over), 32'd1);
      cyc("t4", 1'b0, 2'b01);
      cyc("t4", 1'b0, 2'b00);
      cyc("t4", 1'b0, 2'b10);
      cyc("t4", 1'b1, '0);
      check("t4.cleared", 32'(bus.scores), 32'h00);
      check("t4.serve", 32'(bus.state), 32'd1);
      cyc("t4", 1'b0, '0);
      for (int k = 1; k < int'(DLY); k++) cyc("t4", 1'b0, '0);

      // Reach 2:2, then player 0 scores.
      point("t5", 2'b01);
      point("t5", 2'b01);
      point("t5", 2'b10);
      point("t5", 2'b10);
      cyc("t5", 1'b0, 2'b01);
`ifdef WIN_BY_TWO_EN
      check("t5.no_win", 32'(bus.state), 32'd1);
      for (int k = 0; k < int'(DLY); k++) cyc("t5", 1'b0, '0);
      cyc("t5", 1'b0, 2'b01);
`endif
      check("t5.over", 32'(bus.state), 32'd3);
      check("t5.winner", 32'(bus.winner), 32'b01);

      // Async reset mid-serve at 2:1.
      cyc("t6", 1'b1, '0);
      for (int k = 0; k < int'(DLY); k++) cyc("t6", 1'b0, '0);
      point("t6", 2'b01);
      point("t6", 2'b10);
      cyc("t6", 1'b0, 2'b01);
      check("t6.pre_scores", 32'(bus.scores), 32'h12);
      cyc("t6", 1'b0, '0);
      #4;
      reset = 1'b1;
      #1;
      check("t6.state", 32'(bus.state), 32'd0);
      check("t6.scores", 32'(bus.scores), 32'h00);
      check("t6.ball_en", 32'(bus.ball_enable), 32'd0);
      do_reset();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         bit          s;
         bit [NP-1:0] e;
         if ($urandom_range(0, 599) == 0) do_reset();
         s = ($urandom_range(0, 11) == 0);
         e = ($urandom_range(0, 1) == 0) ? m_pe : NP'($urandom_range(0, (1 << NP) - 1));
         cyc("rnd", s, e);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
